// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - four-digit multiplexed seven-segment scanner, fixed XX.XX format
module seven_seg_scanner #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] ones,
    input  logic [3:0] tens,
    input  logic [3:0] hundreds,
    input  logic [3:0] thousands,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int              CW       = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0]   CNT_LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    logic [3:0]    r_d0;
    logic [3:0]    r_d1;
    logic [3:0]    r_d2;
    logic [3:0]    r_d3;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;

    logic          w_wrap;
    logic [3:0]    w_digit;
    logic [6:0]    w_seg;
    logic [3:0]    w_an;
    logic          w_dp;

    assign w_wrap = (r_cnt == CNT_LAST);

    // Select the digit for the current index and decode it to active-low segments
    always_comb begin
        w_digit = r_d0;
        case (r_idx)
            2'd0: w_digit = r_d0;
            2'd1: w_digit = r_d1;
            2'd2: w_digit = r_d2;
            2'd3: w_digit = r_d3;
            default: w_digit = r_d0;
        endcase

        w_seg = 7'b0111111;
        case (w_digit)
            4'd0: w_seg = 7'b1000000;
            4'd1: w_seg = 7'b1111001;
            4'd2: w_seg = 7'b0100100;
            4'd3: w_seg = 7'b0110000;
            4'd4: w_seg = 7'b0011001;
            4'd5: w_seg = 7'b0010010;
            4'd6: w_seg = 7'b0000010;
            4'd7: w_seg = 7'b1111000;
            4'd8: w_seg = 7'b0000000;
            4'd9: w_seg = 7'b0010000;
            default: w_seg = 7'b0111111;
        endcase

        // Leading tens digit is suppressed when zero so "05.00" reads as " 5.00"
        if ((r_idx == 2'd3) && (w_digit == 4'd0)) begin
            w_seg = 7'b1111111;
        end

        w_an = 4'b1111;
        w_an[r_idx] = 1'b0;

        w_dp = (r_idx == 2'd2) ? 1'b0 : 1'b1;
    end

    // Refresh counter and digit index advance together; reset abandons any partial period
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_idx <= 2'd0;
        end else if (w_wrap) begin
            r_cnt <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Capture registers take all four digits on any load edge and hold otherwise
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_d0 <= 4'd0;
            r_d1 <= 4'd0;
            r_d2 <= 4'd0;
            r_d3 <= 4'd0;
        end else if (load) begin
            r_d0 <= ones;
            r_d1 <= tens;
            r_d2 <= hundreds;
            r_d3 <= thousands;
        end
    end

    // Display drive is registered from pre-edge index and digits, blank while in reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_an  <= 4'b1111;
            r_seg <= 7'b1111111;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= w_an;
            r_seg <= w_seg;
            r_dp  <= w_dp;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb/tb_seven_seg_scanner.sv - table-driven scoreboard bench for seven_seg_scanner
module tb_seven_seg_scanner;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load = 1'b0;
    logic [3:0] ones = 4'd0;
    logic [3:0] tens = 4'd0;
    logic [3:0] hundreds = 4'd0;
    logic [3:0] thousands = 4'd0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    seven_seg_scanner #(.REFRESH_DIV(DIV)) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .ones      (ones),
        .tens      (tens),
        .hundreds  (hundreds),
        .thousands (thousands),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] th;
        logic [3:0] hu;
        logic [3:0] te;
        logic [3:0] on;
        logic [6:0] s3;
        logic [6:0] s2;
        logic [6:0] s1;
        logic [6:0] s0;
    } vec_t;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    vec_t       vecs[7];
    exp_t       sbq[$];
    logic [6:0] m_seg[4];
    int         ecount;
    int         errors = 0;
    int         checks = 0;

    task automatic model_clear();
        m_seg[3] = 7'b1111111;
        m_seg[2] = 7'b1000000;
        m_seg[1] = 7'b1000000;
        m_seg[0] = 7'b1000000;
    endtask

    task automatic check_blank(input string name);
        checks++;
        if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1) begin
            errors++;
            $display("FAIL %s: got an=%b seg=%b dp=%b, want an=1111 seg=1111111 dp=1",
                     name, an, seg, dp);
        end
    endtask

    task automatic step(input logic ld, input int vi, input string name);
        exp_t e;
        exp_t g;
        int   d;
        @(negedge clk);
        load = ld;
        if (ld) begin
            thousands = vecs[vi].th;
            hundreds  = vecs[vi].hu;
            tens      = vecs[vi].te;
            ones      = vecs[vi].on;
        end else begin
            thousands = 4'($urandom_range(0, 15));
            hundreds  = 4'($urandom_range(0, 15));
            tens      = 4'($urandom_range(0, 15));
            ones      = 4'($urandom_range(0, 15));
        end
        d = (ecount / DIV) % 4;
        e.an = 4'b1111;
        e.an[d] = 1'b0;
        e.seg = m_seg[d];
        e.dp = (d == 2) ? 1'b0 : 1'b1;
        sbq.push_back(e);
        if (ld) begin
            m_seg[3] = vecs[vi].s3;
            m_seg[2] = vecs[vi].s2;
            m_seg[1] = vecs[vi].s1;
            m_seg[0] = vecs[vi].s0;
        end
        @(posedge clk);
        #1;
        ecount++;
        g = sbq.pop_front();
        checks++;
        if (an !== g.an || seg !== g.seg || dp !== g.dp) begin
            errors++;
            $display("FAIL %s edge %0d: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                     name, ecount, an, seg, dp, g.an, g.seg, g.dp);
        end
    endtask

    initial begin
        vecs[0] = '{4'h0, 4'h9, 4'h9, 4'h4, 7'b1111111, 7'b0010000, 7'b0010000, 7'b0011001};
        vecs[1] = '{4'h1, 4'h0, 4'h0, 4'h0, 7'b1111001, 7'b1000000, 7'b1000000, 7'b1000000};
        vecs[2] = '{4'h2, 4'h3, 4'hC, 4'h5, 7'b0100100, 7'b0110000, 7'b0111111, 7'b0010010};
        vecs[3] = '{4'h6, 4'h7, 4'h8, 4'hF, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0111111};
        vecs[4] = '{4'hA, 4'h1, 4'h2, 4'h3, 7'b0111111, 7'b1111001, 7'b0100100, 7'b0110000};
        vecs[5] = '{4'h0, 4'h0, 4'h0, 4'h0, 7'b1111111, 7'b1000000, 7'b1000000, 7'b1000000};
        vecs[6] = '{4'h5, 4'h4, 4'hB, 4'h0, 7'b0010010, 7'b0011001, 7'b0111111, 7'b1000000};

        model_clear();
        ecount = 0;

        repeat (2) @(posedge clk);
        #1;
        check_blank("reset_hold");
        #1;
        reset = 1'b1;

        for (int i = 0; i < 20; i++) step(1'b0, 0, "scan_after_reset");

        for (int v = 0; v < 7; v++) begin
            step(1'b1, v, "vec_load");
            for (int i = 0; i < 15; i++) step(1'b0, 0, "vec_scan");
        end

        while (((ecount + 1) % DIV) != 0) step(1'b0, 0, "align_idx_edge");
        step(1'b1, 2, "load_on_idx_edge");
        for (int i = 0; i < 16; i++) step(1'b0, 0, "after_idx_edge_load");

        for (int i = 0; i < 10; i++) step(1'b1, i % 7, "load_held");
        for (int i = 0; i < 16; i++) step(1'b0, 0, "after_load_held");

        step(1'b1, 0, "preload_for_reset");
        while (((ecount / DIV) % 4) != 2 || (ecount % DIV) != 2) step(1'b0, 0, "to_idx2");
        #2;
        reset = 1'b0;
        #1;
        check_blank("async_reset_immediate");
        @(posedge clk);
        #1;
        check_blank("reset_held_edge");
        #1;
        reset = 1'b1;
        load = 1'b0;
        ecount = 0;
        model_clear();
        for (int i = 0; i < 20; i++) step(1'b0, 0, "scan_after_mid_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
